mc_datapath: RTL and testbench
==============================

MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16, max cycles waiting for mem_ack before bus error; 0 disables timeout.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 RegSrc  input  2  bit0: RA1 = 15 else Instr[19:16]; bit1: RA2 = Instr[15:12] else Instr[3:0].
REQ-006 RegWrite, ALUSrc, MemtoReg, PCSrc, MemWrite, MemOp  input  1 each  decoded controls, sampled in the state that uses them.
REQ-007 ImmSrc  input  2  immediate format select; ALUControl  input  2  00 add, 01 sub, 10 and, 11 orr.
REQ-008 mem_req  output  1  memory request; mem_we  output  1  write strobe; mem_addr, mem_wdata  output  32.
REQ-009 mem_rdata  input  32  read data; mem_ack  input  1  completes the request in the same cycle.
REQ-010 PC  output  32; Instr  output  32 (instruction register); ALUFlags  output  4 {N,Z,C,V}.
REQ-011 state  output  3  current FSM state; bus_err  output  1  sticky bus-error flag.

Function
REQ-012 FSM states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7; one instruction per pass FETCH->DECODE->EXEC->(MEM)->WB->FETCH.
REQ-013 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ack, Instr<=mem_rdata, IPC<=PC, PC<=PC+4, go DECODE; without ack, hold state and all registers.
REQ-014 DECODE: A<=RF[RA1], B<=RF[RA2], ExtImm registered; a read of register 15 returns IPC+8.
REQ-015 ExtImm: ImmSrc 00 zero-extended Instr[7:0]; 01 zero-extended Instr[11:0]; 10 sign-extended Instr[23:0] shifted left 2; 11 zero.
REQ-016 EXEC: ALUOut<=A op (ALUSrc ? ExtImm : B); ALUFlags updated in EXEC only; next state MEM if MemOp else WB.
REQ-017 Flags: N=result[31]; Z=(result==0); C=carry-out for add, no-borrow for sub, 0 for and/orr; V=signed overflow for add/sub, 0 otherwise.
REQ-018 MEM: mem_req=1, mem_addr=ALUOut, mem_we=MemWrite, mem_wdata=B; on mem_ack, Data<=mem_rdata if read, go WB; else hold.
REQ-019 WB: Result = MemtoReg ? Data : ALUOut; if RegWrite and Instr[15:12]!=15, RF[Instr[15:12]]<=Result; if PCSrc, PC<=Result; go FETCH.
REQ-020 PCSrc and RegWrite to register 15 in the same WB: PC write wins; no register-file write.
REQ-021 mem_req is 0 in DECODE, EXEC, WB, ERR; mem_we is 1 only in MEM with MemWrite=1.
REQ-022 Wait counter: clears on entering FETCH or MEM and increments each waiting cycle; when TIMEOUT!=0 and count reaches TIMEOUT without ack, go ERR and set bus_err.
REQ-023 mem_ack in the cycle the count reaches TIMEOUT: ack wins, no error.
REQ-024 ERR: terminal; all registers frozen, mem_req=0, exit only via reset.
REQ-025 mem_ack outside FETCH/MEM is ignored.
REQ-026 All arithmetic is modulo 2^32; PC+4 wraps from 32'hFFFF_FFFC to 0.

Reset
REQ-027 reset low asynchronously forces state=FETCH, PC=RESET_PC, Instr=0, ALUFlags=0, bus_err=0, wait counter=0, A=B=ALUOut=Data=0.
REQ-028 Register-file contents are not reset.
REQ-029 reset asserted mid-MEM aborts the access: mem_req and mem_we drop to 0 immediately, and no register or PC write occurs.
REQ-030 The first FETCH request (mem_addr=RESET_PC) is issued in the first cycle after reset deasserts.

Verification
REQ-031 ADD R1,R0,#5 with R0=3, ack in 1 cycle -> R1=8, flags 0000, 4 states visited, PC advances by 4.
REQ-032 SUB setting flags, 5-5 -> Z=1, C=1, N=0, V=0; 32'h8000_0000-1 -> V=1, N=0.
REQ-033 STR then LDR via ALUOut=0x100 with ack delayed 3 cycles -> mem_req held stable for 4 cycles, loaded value written to Rd in WB.
REQ-034 Branch ImmSrc=10, Instr[23:0]=24'hFFFFFE, PCSrc=1, at IPC=0x20 -> PC=0x20 (IPC+8-8).
REQ-035 TIMEOUT=4 with ack never asserted -> ERR after 4 wait cycles, bus_err=1, PC frozen; ack exactly on cycle 4 -> no error.
REQ-036 Reset pulsed during MEM write -> mem_we=0 asynchronously, state=FETCH, PC=RESET_PC, memory sees no completed write.

Source files
------------

// File: rtl/mc_datapath.sv
// Multi-cycle datapath for a small ARM-like core.
// One instruction per pass FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Decoded controls come from an external decoder and are sampled only in the
// state that uses them. Memory-wait timeouts trap into a terminal ERR state.
//
// Memory handshake: mem_req is held high, with mem_addr/mem_we/mem_wdata
// stable, for every cycle spent in FETCH or MEM. The access completes on the
// rising edge where mem_req and mem_ack are both high. mem_ack seen in any
// other state is ignored. Reset low drops mem_req/mem_we immediately.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  RegSrc,
  input  logic        RegWrite,
  input  logic        ALUSrc,
  input  logic        MemtoReg,
  input  logic        PCSrc,
  input  logic        MemWrite,
  input  logic        MemOp,
  input  logic [1:0]  ImmSrc,
  input  logic [1:0]  ALUControl,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic [3:0]  ALUFlags,
  output logic [2:0]  state,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [31:0] TIMEOUT_L  = 32'(TIMEOUT);
  localparam logic        TIMEOUT_EN = (TIMEOUT != 0);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] ext_imm_q, ext_imm_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  flags_q, flags_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  // R15 is never stored; reads of it return IPC+8
  logic [31:0] rf_q [0:15];
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;

  logic [3:0]  ra1, ra2, rd;
  logic [31:0] rd1, rd2;
  logic [31:0] ext_imm_c;
  logic [31:0] src_b;
  logic [32:0] sum33;
  logic [31:0] alu_res;
  logic        alu_c, alu_v;
  logic [3:0]  alu_flags;
  logic [31:0] result;
  logic        mem_req_c, mem_we_c;
  logic [31:0] mem_addr_c;
  logic        wait_expired;

  assign rd  = instr_q[15:12];
  assign ra1 = RegSrc[0] ? 4'd15 : instr_q[19:16];
  assign ra2 = RegSrc[1] ? instr_q[15:12] : instr_q[3:0];

  // Register-file read ports with the R15 = IPC+8 substitution
  always_comb begin
    rd1 = (ra1 == 4'd15) ? (ipc_q + 32'd8) : rf_q[ra1];
    rd2 = (ra2 == 4'd15) ? (ipc_q + 32'd8) : rf_q[ra2];
  end

  // Immediate extension from the instruction register
  always_comb begin
    ext_imm_c = 32'd0;
    case (ImmSrc)
      2'b00:   ext_imm_c = {24'd0, instr_q[7:0]};
      2'b01:   ext_imm_c = {20'd0, instr_q[11:0]};
      2'b10:   ext_imm_c = {{6{instr_q[23]}}, instr_q[23:0], 2'b00};
      default: ext_imm_c = 32'd0;
    endcase
  end

  // ALU with NZCV generation; C on sub is the no-borrow carry
  always_comb begin
    src_b   = ALUSrc ? ext_imm_q : b_q;
    sum33   = 33'd0;
    alu_res = 32'd0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      2'b00: begin
        sum33   = {1'b0, a_q} + {1'b0, src_b};
        alu_res = sum33[31:0];
        alu_c   = sum33[32];
        alu_v   = (a_q[31] == src_b[31]) && (alu_res[31] != a_q[31]);
      end
      2'b01: begin
        sum33   = {1'b0, a_q} + {1'b0, ~src_b} + 33'd1;
        alu_res = sum33[31:0];
        alu_c   = sum33[32];
        alu_v   = (a_q[31] != src_b[31]) && (alu_res[31] != a_q[31]);
      end
      2'b10:   alu_res = a_q & src_b;
      default: alu_res = a_q | src_b;
    endcase
    alu_flags = {alu_res[31], (alu_res == 32'd0), alu_c, alu_v};
  end

  assign result       = MemtoReg ? data_q : alu_out_q;
  assign wait_expired = TIMEOUT_EN && ((wait_cnt_q + 32'd1) == TIMEOUT_L);

  // Next-state, register updates and memory-port drive
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ipc_d      = ipc_q;
    instr_d    = instr_q;
    a_d        = a_q;
    b_d        = b_q;
    ext_imm_d  = ext_imm_q;
    alu_out_d  = alu_out_q;
    data_d     = data_q;
    flags_d    = flags_q;
    bus_err_d  = bus_err_q;
    wait_cnt_d = wait_cnt_q;
    rf_we      = 1'b0;
    rf_wa      = rd;
    rf_wd      = result;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    mem_addr_c = pc_q;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ack) begin
          instr_d    = mem_rdata;
          ipc_d      = pc_q;
          pc_d       = pc_q + 32'd4;
          wait_cnt_d = 32'd0;
          state_d    = S_DECODE;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
          if (wait_expired) begin
            bus_err_d = 1'b1;
            state_d   = S_ERR;
          end
        end
      end
      S_DECODE: begin
        a_d       = rd1;
        b_d       = rd2;
        ext_imm_d = ext_imm_c;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        alu_out_d = alu_res;
        flags_d   = alu_flags;
        if (MemOp) begin
          wait_cnt_d = 32'd0;
          state_d    = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req_c  = 1'b1;
        mem_we_c   = MemWrite;
        mem_addr_c = alu_out_q;
        if (mem_ack) begin
          if (!MemWrite) data_d = mem_rdata;
          state_d = S_WB;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
          if (wait_expired) begin
            bus_err_d = 1'b1;
            state_d   = S_ERR;
          end
        end
      end
      S_WB: begin
        // A PC write always wins; R15 never lands in the register file
        if (PCSrc) pc_d = result;
        rf_we      = RegWrite && (rd != 4'd15);
        wait_cnt_d = 32'd0;
        state_d    = S_FETCH;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        wait_cnt_d = 32'd0;
        state_d    = S_FETCH;
      end
    endcase
  end

  // State and datapath registers, asynchronously reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ipc_q      <= 32'd0;
      instr_q    <= 32'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      ext_imm_q  <= 32'd0;
      alu_out_q  <= 32'd0;
      data_q     <= 32'd0;
      flags_q    <= 4'd0;
      bus_err_q  <= 1'b0;
      wait_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ipc_q      <= ipc_d;
      instr_q    <= instr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ext_imm_q  <= ext_imm_d;
      alu_out_q  <= alu_out_d;
      data_q     <= data_d;
      flags_q    <= flags_d;
      bus_err_q  <= bus_err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Register file write port; contents survive reset
  always_ff @(posedge clk) begin
    if (rf_we) rf_q[rf_wa] <= rf_wd;
  end

  // Memory strobes are cut by reset so an in-flight access aborts at once
  assign mem_req   = reset & mem_req_c;
  assign mem_we    = reset & mem_we_c;
  assign mem_addr  = mem_addr_c;
  assign mem_wdata = b_q;

  assign PC       = pc_q;
  assign Instr    = instr_q;
  assign ALUFlags = flags_q;
  assign state    = state_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: drives decoded controls and acts as the
// memory, observing register contents through store read-backs.
module tb_mc_datapath;

  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2,
                         MEM = 3'd3, WB = 3'd4, ERR = 3'd7;

  logic        clk, reset;
  logic [1:0]  RegSrc, ImmSrc, ALUControl;
  logic        RegWrite, ALUSrc, MemtoReg, PCSrc, MemWrite, MemOp;
  logic        mem_req, mem_we, mem_ack, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, PC, Instr;
  logic [3:0]  ALUFlags;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  // results of the last run_instr
  int          n_states, req_cyc, wr_cnt;
  logic        addr_stable, we_in_mem;
  logic [31:0] fetch_addr, mem_addr0, wr_addr, wr_data;

  mc_datapath #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .RegSrc(RegSrc), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .PCSrc(PCSrc), .MemWrite(MemWrite), .MemOp(MemOp),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .PC(PC), .Instr(Instr), .ALUFlags(ALUFlags), .state(state), .bus_err(bus_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory side: record every completed write
  initial wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ack) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = mem_addr;
      wr_data = mem_wdata;
    end
  end

  function automatic logic [31:0] mk(input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] imm);
    return {12'h000, rn, rd, imm};
  endfunction

  task automatic set_ctl(input logic [1:0] rs, input logic rw, input logic as,
                         input logic mr, input logic ps, input logic mw,
                         input logic mo, input logic [1:0] is, input logic [1:0] ac);
    RegSrc = rs; RegWrite = rw; ALUSrc = as; MemtoReg = mr; PCSrc = ps;
    MemWrite = mw; MemOp = mo; ImmSrc = is; ALUControl = ac;
  endtask

  // Runs one instruction from FETCH back to FETCH. Entered at a negedge in FETCH.
  task automatic run_instr(input logic [31:0] instr, input int fdly, input int mdly,
                           input logic [31:0] ld_val);
    int fw, mw, c;
    logic [2:0] prev;
    logic left, done;
    fw = 0; mw = 0; c = 0; prev = 3'd6; left = 1'b0; done = 1'b0;
    n_states = 0; req_cyc = 0; addr_stable = 1'b1; we_in_mem = 1'b0;
    fetch_addr = mem_addr; mem_addr0 = 32'd0;
    while (!done && c < 64) begin
      if ((state == FETCH && left) || state == ERR) begin
        done = 1'b1;
      end else begin
        if (state != prev) begin n_states++; prev = state; end
        if (state == FETCH) begin
          if (fw < fdly) begin mem_ack = 1'b0; fw++; end
          else begin mem_ack = 1'b1; mem_rdata = instr; end
        end else if (state == MEM) begin
          left = 1'b1;
          if (req_cyc == 0) begin mem_addr0 = mem_addr; we_in_mem = mem_we; end
          else if (mem_addr !== mem_addr0 || mem_we !== we_in_mem) addr_stable = 1'b0;
          if (mem_req) req_cyc++;
          if (mw < mdly) begin mem_ack = 1'b0; mw++; end
          else begin mem_ack = 1'b1; mem_rdata = ld_val; end
        end else begin
          // stray acks outside FETCH/MEM must be ignored
          left = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        c++;
      end
    end
    mem_ack = 1'b0;
    checks++;
    if (!done || state !== FETCH) begin
      errors++;
      $display("FAIL run_instr_end: state=%0d done=%0d want state=0", state, done);
    end
  endtask

  // Stores register r to IPC+8 and returns the written data
  task automatic read_reg(input logic [3:0] r, output logic [31:0] v);
    set_ctl(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b00);
    run_instr(mk(4'd0, r, 12'd0), 0, 0, 32'd0);
    v = wr_data;
  endtask

  task automatic test_reset;
    reset = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    set_ctl(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    checks++; if (state !== FETCH) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
    checks++; if (PC !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h want 0", PC); end
    checks++; if (Instr !== 32'd0) begin errors++; $display("FAIL rst_instr: got %h want 0", Instr); end
    checks++; if (ALUFlags !== 4'd0 || bus_err !== 1'b0) begin errors++; $display("FAIL rst_flags: flags=%b bus_err=%b want 0000/0", ALUFlags, bus_err); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_req_low: req=%b we=%b want 0/0", mem_req, mem_we); end
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd0) begin errors++; $display("FAIL rst_first_fetch: req=%b we=%b addr=%h want 1/0/0", mem_req, mem_we, mem_addr); end
  endtask

  task automatic test_add;
    logic [31:0] v;
    // AND R0,R0,#0 (zero immediate)
    set_ctl(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b10);
    run_instr(mk(4'd0, 4'd0, 12'd0), 0, 0, 32'd0);
    checks++; if (ALUFlags !== 4'b0100) begin errors++; $display("FAIL and_zero_flags: got %b want 0100", ALUFlags); end
    // ADD R0,R0,#3
    set_ctl(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    run_instr(mk(4'd0, 4'd0, 12'd3), 0, 0, 32'd0);
    // ADD R1,R0,#5
    run_instr(mk(4'd0, 4'd1, 12'd5), 0, 0, 32'd0);
    checks++; if (fetch_addr !== 32'h8) begin errors++; $display("FAIL add_fetch_addr: got %h want 8", fetch_addr); end
    checks++; if (n_states !== 4) begin errors++; $display("FAIL add_states: got %0d want 4", n_states); end
    checks++; if (PC !== 32'hC) begin errors++; $display("FAIL add_pc: got %h want c", PC); end
    checks++; if (ALUFlags !== 4'b0000) begin errors++; $display("FAIL add_flags: got %b want 0000", ALUFlags); end
    read_reg(4'd1, v);
    checks++; if (v !== 32'd8) begin errors++; $display("FAIL add_r1: got %h want 8", v); end
    checks++; if (wr_addr !== 32'h14 || n_states !== 5) begin errors++; $display("FAIL str_r15_addr: addr=%h states=%0d want 14/5", wr_addr, n_states); end
  endtask

  task automatic test_sub_flags;
    // ADD R2,R0,#2 -> 5 ; SUB R3,R2,#5 -> 0
    set_ctl(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    run_instr(mk(4'd0, 4'd2, 12'd2), 0, 0, 32'd0);
    set_ctl(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
    run_instr(mk(4'd2, 4'd3, 12'd5), 0, 0, 32'd0);
    checks++; if (ALUFlags !== 4'b0110) begin errors++; $display("FAIL sub_zero_flags: got %b want 0110", ALUFlags); end
    // LDR R4,[R15,#0] loads 0x8000_0000
    set_ctl(2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00);
    run_instr(mk(4'd0, 4'd4, 12'd0), 0, 0, 32'h8000_0000);
    checks++; if (mem_addr0 !== 32'h20) begin errors++; $display("FAIL ldr_pc_addr: got %h want 20", mem_addr0); end
    // SUB R5,R4,#1 -> 0x7FFF_FFFF with overflow
    set_ctl(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
    run_instr(mk(4'd4, 4'd5, 12'd1), 0, 0, 32'd0);
    checks++; if (ALUFlags !== 4'b0011) begin errors++; $display("FAIL sub_ovf_flags: got %b want 0011", ALUFlags); end
  endtask

  task automatic test_branch;
    set_ctl(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00);
    run_instr(32'h00FF_FFFE, 0, 0, 32'd0);
    checks++; if (fetch_addr !== 32'h20) begin errors++; $display("FAIL br_ipc: got %h want 20", fetch_addr); end
    checks++; if (PC !== 32'h20 || mem_addr !== 32'h20) begin errors++; $display("FAIL br_target: pc=%h addr=%h want 20/20", PC, mem_addr); end
    checks++; if (ALUFlags !== 4'b0010) begin errors++; $display("FAIL br_flags: got %b want 0010", ALUFlags); end
  endtask

  task automatic test_ldr_str;
    logic [31:0] v;
    int w0;
    // ADD R6,R3,#0x100
    set_ctl(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    run_instr(mk(4'd3, 4'd6, 12'h100), 0, 0, 32'd0);
    // STR R5,[R6] with fetch and memory ack delayed 3 cycles
    w0 = wr_cnt;
    set_ctl(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b00);
    run_instr(mk(4'd6, 4'd5, 12'd0), 3, 3, 32'd0);
    checks++; if (req_cyc !== 4 || addr_stable !== 1'b1 || we_in_mem !== 1'b1) begin errors++; $display("FAIL str_hold: cycles=%0d stable=%b we=%b want 4/1/1", req_cyc, addr_stable, we_in_mem); end
    checks++; if (wr_cnt !== w0 + 1 || wr_addr !== 32'h100 || wr_data !== 32'h7FFF_FFFF) begin errors++; $display("FAIL str_write: n=%0d addr=%h data=%h want 1/100/7fffffff", wr_cnt - w0, wr_addr, wr_data); end
    // LDR R7,[R6]
    set_ctl(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00);
    run_instr(mk(4'd6, 4'd7, 12'd0), 3, 3, 32'h1234_5678);
    checks++; if (req_cyc !== 4 || we_in_mem !== 1'b0 || mem_addr0 !== 32'h100) begin errors++; $display("FAIL ldr_hold: cycles=%0d we=%b addr=%h want 4/0/100", req_cyc, we_in_mem, mem_addr0); end
    checks++; if (bus_err !== 1'b0 || PC !== 32'h2C) begin errors++; $display("FAIL ack_at_limit: bus_err=%b pc=%h want 0/2c", bus_err, PC); end
    read_reg(4'd7, v);
    checks++; if (v !== 32'h1234_5678) begin errors++; $display("FAIL ldr_r7: got %h want 12345678", v); end
  endtask

  task automatic test_alu_ops;
    // STR R5,[R6 | 0x0F]
    set_ctl(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b11);
    run_instr(mk(4'd6, 4'd5, 12'h00F), 0, 0, 32'd0);
    checks++; if (wr_addr !== 32'h10F || ALUFlags !== 4'b0000) begin errors++; $display("FAIL orr_addr: addr=%h flags=%b want 10f/0000", wr_addr, ALUFlags); end
    // STR R6,[R5 & 0xFF]
    set_ctl(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10);
    run_instr(mk(4'd5, 4'd6, 12'h0FF), 0, 0, 32'd0);
    checks++; if (wr_addr !== 32'hFF || wr_data !== 32'h100) begin errors++; $display("FAIL and_addr: addr=%h data=%h want ff/100", wr_addr, wr_data); end
  endtask

  task automatic test_pc_write;
    // ADD R15,R3,#0x40 with PCSrc: PC takes the result
    set_ctl(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00);
    run_instr(mk(4'd3, 4'd15, 12'h040), 0, 0, 32'd0);
    checks++; if (PC !== 32'h40) begin errors++; $display("FAIL pc_wins: got %h want 40", PC); end
    // RegWrite to R15 without PCSrc changes nothing
    set_ctl(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    run_instr(mk(4'd3, 4'd15, 12'h080), 0, 0, 32'd0);
    checks++; if (PC !== 32'h44) begin errors++; $display("FAIL r15_no_pc: got %h want 44", PC); end
  endtask

  task automatic test_wrap;
    logic [31:0] v;
    // SUB R9,R3,#4 with PCSrc -> PC = 0xFFFF_FFFC
    set_ctl(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
    run_instr(mk(4'd3, 4'd9, 12'd4), 0, 0, 32'd0);
    checks++; if (PC !== 32'hFFFF_FFFC || ALUFlags !== 4'b1000) begin errors++; $display("FAIL neg_branch: pc=%h flags=%b want fffffffc/1000", PC, ALUFlags); end
    // AND R10,R3,#0 at the top of memory
    set_ctl(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b10);
    run_instr(mk(4'd3, 4'd10, 12'd0), 0, 0, 32'd0);
    checks++; if (fetch_addr !== 32'hFFFF_FFFC || PC !== 32'd0) begin errors++; $display("FAIL pc_wrap: fetch=%h pc=%h want fffffffc/0", fetch_addr, PC); end
    read_reg(4'd9, v);
    checks++; if (v !== 32'hFFFF_FFFC) begin errors++; $display("FAIL r9_with_pc: got %h want fffffffc", v); end
  endtask

  task automatic test_timeout;
    logic [31:0] pc0, ins0;
    pc0 = PC; ins0 = Instr;
    mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state !== FETCH || bus_err !== 1'b0) begin errors++; $display("FAIL to_wait3: state=%0d bus_err=%b want 0/0", state, bus_err); end
    @(negedge clk);
    checks++; if (state !== ERR || bus_err !== 1'b1) begin errors++; $display("FAIL to_err: state=%0d bus_err=%b want 7/1", state, bus_err); end
    checks++; if (mem_req !== 1'b0 || PC !== pc0) begin errors++; $display("FAIL to_frozen: req=%b pc=%h want 0/%h", mem_req, PC, pc0); end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    checks++; if (state !== ERR || PC !== pc0 || Instr !== ins0 || bus_err !== 1'b1) begin errors++; $display("FAIL err_terminal: state=%0d pc=%h instr=%h want 7/%h/%h", state, PC, Instr, pc0, ins0); end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_mem;
    logic [31:0] v;
    int w0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus_err !== 1'b0 || state !== FETCH) begin errors++; $display("FAIL err_cleared: bus_err=%b state=%0d want 0/0", bus_err, state); end
    // STR R5,[R6], reset pulsed while the write waits for ack
    set_ctl(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b00);
    mem_ack = 1'b1; mem_rdata = mk(4'd6, 4'd5, 12'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (state !== MEM || mem_we !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL pre_abort: state=%0d we=%b req=%b want 3/1/1", state, mem_we, mem_req); end
    w0 = wr_cnt;
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL abort_strobes: we=%b req=%b want 0/0", mem_we, mem_req); end
    checks++; if (state !== FETCH || PC !== 32'd0) begin errors++; $display("FAIL abort_state: state=%0d pc=%h want 0/0", state, PC); end
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL abort_no_write: writes=%0d want 0", wr_cnt - w0); end
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL refetch: req=%b addr=%h we=%b want 1/0/0", mem_req, mem_addr, mem_we); end
    read_reg(4'd5, v);
    checks++; if (v !== 32'h7FFF_FFFF) begin errors++; $display("FAIL rf_kept: got %h want 7fffffff", v); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_flags();
    test_branch();
    test_ldr_str();
    test_alu_ops();
    test_pc_write();
    test_wrap();
    test_timeout();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
